// File: rtl/btn_event_reader.sv
// Debounced active-low button reader: synchronises pins, commits stable vectors,
// and queues per-bit press/release events behind a valid/ready port.
module btn_event_reader #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [3:0] btn_n,
  input  logic       any_in,
  input  logic       evt_ready,
  input  logic       clr_flags,
  output logic       evt_valid,
  output logic [2:0] evt_code,
  output logic       overflow,
  output logic       any_mismatch,
  output logic [3:0] pressed
);

  localparam int          PW       = $clog2(FIFO_DEPTH);
  localparam int          CW       = PW + 1;
  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_EMIT
  } state_t;

  logic [3:0]    btn_meta_q, s_q;
  logic          any_meta_q, sa_q;
  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    committed_q, committed_d;
  logic [3:0]    mask_q, mask_d;
  logic [3:0]    pressed_q, pressed_d;
  logic          overflow_q, overflow_d;
  logic          mism_q, mism_d;
  logic [2:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          push, push_ok, pop, full, mism_set;
  logic [1:0]    emit_idx;
  logic [2:0]    push_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta_q <= 4'b1111;
      s_q        <= 4'b1111;
      any_meta_q <= 1'b0;
      sa_q       <= 1'b0;
    end else begin
      btn_meta_q <= btn_n;
      s_q        <= btn_meta_q;
      any_meta_q <= any_in;
      sa_q       <= any_meta_q;
    end
  end

  // Lowest set mask bit wins so events leave in ascending index order.
  always_comb begin
    emit_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask_q[i]) emit_idx = 2'(i);
    end
    push_code = {~committed_q[emit_idx], emit_idx};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    committed_d = committed_q;
    mask_d      = mask_q;
    pressed_d   = pressed_q;
    push        = 1'b0;
    mism_set    = 1'b0;
    if (ena) begin
      case (state_q)
        ST_IDLE: begin
          if (s_q != committed_q) begin
            cand_d  = s_q;
            cnt_d   = 16'd0;
            state_d = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (s_q != cand_q) begin
            cand_d = s_q;
            cnt_d  = 16'd0;
          end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + 16'd1;
          end else if (cand_q == committed_q) begin
            state_d = ST_IDLE;
          end else begin
            mask_d      = cand_q ^ committed_q;
            committed_d = cand_q;
            pressed_d   = ~cand_q;
            mism_set    = (sa_q != |(~cand_q));
            state_d     = ST_EMIT;
          end
        end
        ST_EMIT: begin
          push             = 1'b1;
          mask_d[emit_idx] = 1'b0;
          if (mask_d == 4'b0000) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A pop in the same cycle frees the slot, so a push on full still lands.
  always_comb begin
    full     = (count_q == FULL_CNT);
    pop      = (count_q != '0) && evt_ready;
    push_ok  = push && (!full || pop);
    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push_ok) count_d = count_q - CW'(1);

    overflow_d = overflow_q;
    mism_d     = mism_q;
    if (clr_flags) begin
      overflow_d = 1'b0;
      mism_d     = 1'b0;
    end
    if (push && !push_ok) overflow_d = 1'b1;
    if (mism_set)         mism_d     = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 16'd0;
      cand_q      <= 4'b1111;
      committed_q <= 4'b1111;
      mask_q      <= 4'b0000;
      pressed_q   <= 4'b0000;
      overflow_q  <= 1'b0;
      mism_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 3'b000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      committed_q <= committed_d;
      mask_q      <= mask_d;
      pressed_q   <= pressed_d;
      overflow_q  <= overflow_d;
      mism_q      <= mism_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      if (push_ok) mem_q[wr_ptr_q] <= push_code;
    end
  end

  assign evt_valid    = (count_q != '0);
  assign evt_code     = mem_q[rd_ptr_q];
  assign overflow     = overflow_q;
  assign any_mismatch = mism_q;
  assign pressed      = pressed_q;

endmodule

// File: tb/tb_btn_event_reader.sv
// Directed bench for btn_event_reader with a 4-cycle debounce window.
module tb_btn_event_reader;
  logic       clk = 1'b0;
  logic       rst_n, ena, any_in, evt_ready, clr_flags;
  logic [3:0] btn_n;
  logic       evt_valid, overflow, any_mismatch;
  logic [2:0] evt_code;
  logic [3:0] pressed;
  int total = 0;
  int bad   = 0;

  btn_event_reader #(.DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .btn_n(btn_n), .any_in(any_in),
    .evt_ready(evt_ready), .clr_flags(clr_flags), .evt_valid(evt_valid),
    .evt_code(evt_code), .overflow(overflow), .any_mismatch(any_mismatch),
    .pressed(pressed)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ena = 1'b1; btn_n = 4'b1111; any_in = 1'b0;
    evt_ready = 1'b0; clr_flags = 1'b0;
    step(3);
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", evt_valid); end
    total++; if (evt_code !== 3'b000) begin bad++; $display("FAIL reset_code got=%b want=000", evt_code); end
    total++; if (pressed !== 4'b0000) begin bad++; $display("FAIL reset_pressed got=%b want=0000", pressed); end
    total++; if ({overflow, any_mismatch} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b want=00", {overflow, any_mismatch}); end
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_single_press;
    btn_n = 4'b1110; any_in = 1'b1;
    step(7);
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL single_early got=%b want=0", evt_valid); end
    total++; if (pressed !== 4'b0001) begin bad++; $display("FAIL single_pressed got=%b want=0001", pressed); end
    step(1);
    total++; if (evt_valid !== 1'b1) begin bad++; $display("FAIL single_latency got=%b want=1", evt_valid); end
    total++; if (evt_code !== 3'b100) begin bad++; $display("FAIL single_code got=%b want=100", evt_code); end
    step(3);
    total++; if (evt_code !== 3'b100) begin bad++; $display("FAIL single_hold got=%b want=100", evt_code); end
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL single_pop got=%b want=0", evt_valid); end
    btn_n = 4'b1111; any_in = 1'b0;
    step(8);
    total++; if ({evt_valid, evt_code} !== 4'b1000) begin bad++; $display("FAIL single_release got=%b want=1000", {evt_valid, evt_code}); end
    total++; if (pressed !== 4'b0000) begin bad++; $display("FAIL single_rel_pressed got=%b want=0000", pressed); end
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
  endtask

  task automatic test_glitch;
    btn_n = 4'b1101;
    step(3);
    btn_n = 4'b1111;
    step(20);
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL glitch_valid got=%b want=0", evt_valid); end
    total++; if (pressed !== 4'b0000) begin bad++; $display("FAIL glitch_pressed got=%b want=0000", pressed); end
  endtask

  task automatic test_simultaneous;
    logic [2:0] exp;
    evt_ready = 1'b1; any_in = 1'b1; btn_n = 4'b0000;
    step(7);
    total++; if (pressed !== 4'b1111) begin bad++; $display("FAIL sim_pressed got=%b want=1111", pressed); end
    total++; if (any_mismatch !== 1'b0) begin bad++; $display("FAIL sim_nomismatch got=%b want=0", any_mismatch); end
    for (int k = 0; k < 4; k++) begin
      step(1);
      exp = {1'b1, 2'(k)};
      total++; if ({evt_valid, evt_code} !== {1'b1, exp}) begin bad++; $display("FAIL sim_press_evt%0d got=%b want=%b", k, {evt_valid, evt_code}, {1'b1, exp}); end
    end
    step(1);
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL sim_drain got=%b want=0", evt_valid); end
    btn_n = 4'b1111;
    step(7);
    total++; if (any_mismatch !== 1'b1) begin bad++; $display("FAIL sim_mismatch got=%b want=1", any_mismatch); end
    for (int k = 0; k < 4; k++) begin
      step(1);
      exp = {1'b0, 2'(k)};
      total++; if ({evt_valid, evt_code} !== {1'b1, exp}) begin bad++; $display("FAIL sim_rel_evt%0d got=%b want=%b", k, {evt_valid, evt_code}, {1'b1, exp}); end
    end
    step(1);
    evt_ready = 1'b0; any_in = 1'b0;
    clr_flags = 1'b1;
    step(1);
    clr_flags = 1'b0;
    total++; if (any_mismatch !== 1'b0) begin bad++; $display("FAIL sim_clr got=%b want=0", any_mismatch); end
  endtask

  task automatic test_overflow;
    logic [2:0] exp;
    any_in = 1'b1; btn_n = 4'b0000;
    step(14);
    any_in = 1'b0; btn_n = 4'b1111;
    step(14);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", overflow); end
    for (int k = 0; k < 4; k++) begin
      exp = {1'b1, 2'(k)};
      total++; if ({evt_valid, evt_code} !== {1'b1, exp}) begin bad++; $display("FAIL ovf_keep%0d got=%b want=%b", k, {evt_valid, evt_code}, {1'b1, exp}); end
      evt_ready = 1'b1;
      step(1);
      evt_ready = 1'b0;
    end
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%b want=0", evt_valid); end
    clr_flags = 1'b1;
    step(1);
    clr_flags = 1'b0;
    any_in = 1'b1; btn_n = 4'b0000;
    step(14);
    any_in = 1'b0; btn_n = 4'b1111;
    step(7);
    evt_ready = 1'b1;
    step(4);
    evt_ready = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_pushpop got=%b want=0", overflow); end
    total++; if ({evt_valid, evt_code} !== 4'b1000) begin bad++; $display("FAIL ovf_head got=%b want=1000", {evt_valid, evt_code}); end
    evt_ready = 1'b1;
    step(4);
    evt_ready = 1'b0;
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL ovf_drain got=%b want=0", evt_valid); end
  endtask

  task automatic test_ena_hold;
    any_in = 1'b1; btn_n = 4'b1110;
    step(4);
    ena = 1'b0;
    step(10);
    ena = 1'b1;
    step(3);
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL ena_early got=%b want=0", evt_valid); end
    step(1);
    total++; if ({evt_valid, evt_code} !== 4'b1100) begin bad++; $display("FAIL ena_latency got=%b want=1100", {evt_valid, evt_code}); end
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    btn_n = 4'b0000;
    step(9);
    total++; if (evt_valid !== 1'b1) begin bad++; $display("FAIL rmid_queued got=%b want=1", evt_valid); end
    #3 rst_n = 1'b0;
    #1;
    total++; if ({evt_valid, evt_code} !== 4'b0000) begin bad++; $display("FAIL rmid_async got=%b want=0000", {evt_valid, evt_code}); end
    total++; if (pressed !== 4'b0000) begin bad++; $display("FAIL rmid_pressed got=%b want=0000", pressed); end
    btn_n = 4'b1111; any_in = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(20);
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL rmid_noevt got=%b want=0", evt_valid); end
    total++; if ({overflow, any_mismatch} !== 2'b00) begin bad++; $display("FAIL rmid_flags got=%b want=00", {overflow, any_mismatch}); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_simultaneous();
    test_overflow();
    test_ena_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
